pow_target_check: RTL and testbench

Byte-serial proof-of-work target checker. It sits downstream of the 8-bit magnitude comparator stage and applies that compare byte by byte to a streamed hash, most significant byte first. It decides whether the full NUM_BYTES-wide hash is strictly below a latched difficulty target and reports one result per hash through a valid/ready handshake.

---
 rtl/pow_target_check.sv | 109 ++++++++++
 tb/tb_pow_target_check.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pow_target_check.sv
// Byte-serial check of a streamed hash (MSB first) against a latched difficulty target.
// Optional saturating hit counter is enabled by defining POW_HIT_COUNT_EN.
module pow_target_check #(
   parameter int NUM_BYTES = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [8*NUM_BYTES-1:0] target,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [7:0]             s_data,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic                   res_hit,
   output logic                   res_equal,
   output logic                   busy,
   output logic [15:0]            hit_count
);

   localparam int IDX_W = $clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t state, state_next;

   logic [8*NUM_BYTES-1:0] target_q;
   logic [IDX_W-1:0]       idx;
   logic                   decided;
   logic                   lt;
   logic [7:0]             tgt_bytes [NUM_BYTES];
   logic [7:0]             tgt_byte;
   logic                   accept;
   logic                   res_fire;

   // Element 0 holds the most significant target byte so idx walks in stream order.
   for (genvar i = 0; i < NUM_BYTES; i++) begin : g_tgt_bytes
      assign tgt_bytes[i] = target_q[8*(NUM_BYTES-i)-1 -: 8];
   end

   assign tgt_byte = tgt_bytes[idx];
   assign accept   = s_valid && (state == COMPARE);
   assign res_fire = res_ready && (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = COMPARE;
         COMPARE: if (accept && idx == LAST_IDX) state_next = DONE;
         DONE:    if (res_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         target_q <= '0;
         idx      <= '0;
         decided  <= 1'b0;
         lt       <= 1'b0;
      end else if (state == IDLE && start) begin
         target_q <= target;
         idx      <= '0;
         decided  <= 1'b0;
         lt       <= 1'b0;
      end else if (accept) begin
         if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
         // The first differing byte settles the compare; later bytes only drain.
         if (!decided && s_data != tgt_byte) begin
            decided <= 1'b1;
            lt      <= (s_data < tgt_byte);
         end
      end
   end

   assign s_ready   = (state == COMPARE);
   assign res_valid = (state == DONE);
   assign res_hit   = (state == DONE) && lt;
   assign res_equal = (state == DONE) && !decided;
   assign busy      = (state != IDLE);

`ifdef POW_HIT_COUNT_EN
   logic [15:0] hit_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         hit_count_q <= 16'h0000;
      else if (res_fire && lt && hit_count_q != 16'hFFFF)
         hit_count_q <= hit_count_q + 16'h0001;
   end

   assign hit_count = hit_count_q;
`else
   logic unused_fire;
   assign unused_fire = res_fire;
   assign hit_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_pow_target_check.sv
// Directed bench for pow_target_check with NUM_BYTES=4 and target 32'h00FF0000.
module tb_pow_target_check;

   localparam int NB = 4;
   localparam logic [31:0] TGT = 32'h00FF0000;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [31:0]   target;
   logic          s_valid;
   logic          s_ready;
   logic [7:0]    s_data;
   logic          res_valid;
   logic          res_ready;
   logic          res_hit;
   logic          res_equal;
   logic          busy;
   logic [15:0]   hit_count;

   int checks;
   int errors;
   int cyc;
   int start_cyc;

   pow_target_check #(.NUM_BYTES(NB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .target    (target),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_hit   (res_hit),
      .res_equal (res_equal),
      .busy      (busy),
      .hit_count (hit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse start for one cycle; returns at the negedge where COMPARE is visible.
   task automatic do_start(input logic [31:0] t);
      @(negedge clk);
      start     = 1'b1;
      target    = t;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Stream 4 bytes MSB first, with 'gap' idle cycles before each byte after the first.
   task automatic stream(input logic [31:0] h, input int gap);
      for (int i = 0; i < NB; i++) begin
         if (gap > 0 && i > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         s_valid = 1'b1;
         s_data  = h[31-8*i -: 8];
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({s_ready, res_valid, res_hit, res_equal, busy} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000", {s_ready, res_valid, res_hit, res_equal, busy});
      end
      checks++;
      if (hit_count !== 16'h0000) begin
         errors++;
         $display("FAIL reset_hit_count: got %h expected 0000", hit_count);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_hit_stream();
      res_ready = 1'b1;
      do_start(TGT);
      checks++;
      if ({s_ready, busy} !== 2'b11) begin
         errors++;
         $display("FAIL hit_start_ready: got %b expected 11", {s_ready, busy});
      end
      stream(32'h00FE1234, 0);
      checks++;
      if (res_valid !== 1'b1 || (cyc - start_cyc) != 5) begin
         errors++;
         $display("FAIL hit_latency: res_valid %b after %0d cycles, expected 1 after 5", res_valid, cyc - start_cyc);
      end
      checks++;
      if ({res_hit, res_equal} !== 2'b10 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL hit_result: hit/eq/s_ready %b%b%b expected 100", res_hit, res_equal, s_ready);
      end
      @(negedge clk);
      checks++;
      if ({res_valid, busy, res_hit} !== 3'b000) begin
         errors++;
         $display("FAIL hit_release: valid/busy/hit %b expected 000", {res_valid, busy, res_hit});
      end
   endtask

   task automatic test_miss_early();
      res_ready = 1'b1;
      do_start(TGT);
      stream(32'h01000000, 0);
      checks++;
      if (res_valid !== 1'b1 || (cyc - start_cyc) != 5) begin
         errors++;
         $display("FAIL miss_latency: res_valid %b after %0d cycles, expected 1 after 5", res_valid, cyc - start_cyc);
      end
      checks++;
      if ({res_hit, res_equal} !== 2'b00) begin
         errors++;
         $display("FAIL miss_result: hit/eq %b%b expected 00", res_hit, res_equal);
      end
      @(negedge clk);
   endtask

   task automatic test_equal();
      res_ready = 1'b1;
      do_start(TGT);
      target = 32'hFFFFFFFF;
      stream(32'h00FF0000, 0);
      checks++;
      if ({res_valid, res_hit, res_equal} !== 3'b101) begin
         errors++;
         $display("FAIL equal_result: valid/hit/eq %b expected 101", {res_valid, res_hit, res_equal});
      end
      @(negedge clk);
   endtask

   task automatic test_gap_hold();
      res_ready = 1'b0;
      do_start(TGT);
      stream(32'h00FE0000, 3);
      checks++;
      if (res_valid !== 1'b1 || (cyc - start_cyc) != 14) begin
         errors++;
         $display("FAIL gap_latency: res_valid %b after %0d cycles, expected 1 after 14", res_valid, cyc - start_cyc);
      end
      for (int k = 0; k < 5; k++) begin
         start = (k == 2);
         @(negedge clk);
         checks++;
         if ({res_valid, res_hit, res_equal, busy} !== 4'b1101) begin
            errors++;
            $display("FAIL gap_hold_%0d: valid/hit/eq/busy %b expected 1101", k, {res_valid, res_hit, res_equal, busy});
         end
      end
      res_ready = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({res_valid, busy, s_ready} !== 3'b000) begin
         errors++;
         $display("FAIL gap_release: valid/busy/s_ready %b expected 000", {res_valid, busy, s_ready});
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL handshake_start_ignored: busy %b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b1;
      do_start(TGT);
      s_valid = 1'b1;
      s_data  = 8'h00;
      repeat (2) @(negedge clk);
      s_valid = 1'b0;
      rst_n   = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_ready, res_valid, res_hit, res_equal, busy} !== 5'b00000 || hit_count !== 16'h0000) begin
         errors++;
         $display("FAIL mid_reset: outputs %b count %h expected 00000 0000",
                  {s_ready, res_valid, res_hit, res_equal, busy}, hit_count);
      end
      rst_n = 1'b1;
      do_start(TGT);
      stream(32'h00000001, 0);
      checks++;
      if ({res_valid, res_hit, res_equal} !== 3'b110) begin
         errors++;
         $display("FAIL mid_reset_rerun: valid/hit/eq %b expected 110", {res_valid, res_hit, res_equal});
      end
      @(negedge clk);
   endtask

   task automatic test_hit_count();
      logic [31:0] hashes [4];
      logic        exp_hit [4];
      hashes[0] = 32'h00FE1234; exp_hit[0] = 1'b1;
      hashes[1] = 32'h00000001; exp_hit[1] = 1'b1;
      hashes[2] = 32'h01000000; exp_hit[2] = 1'b0;
      hashes[3] = 32'h00FE0000; exp_hit[3] = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      res_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         do_start(TGT);
         stream(hashes[n], 0);
         checks++;
         if (res_valid !== 1'b1 || res_hit !== exp_hit[n]) begin
            errors++;
            $display("FAIL count_hash_%0d: valid/hit %b%b expected 1%b", n, res_valid, res_hit, exp_hit[n]);
         end
         @(negedge clk);
      end
      checks++;
`ifdef POW_HIT_COUNT_EN
      if (hit_count !== 16'd3) begin
         errors++;
         $display("FAIL hit_count: got %0d expected 3", hit_count);
      end
`else
      if (hit_count !== 16'd0) begin
         errors++;
         $display("FAIL hit_count: got %0d expected 0", hit_count);
      end
`endif
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      start_cyc = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      target    = '0;
      s_valid   = 1'b0;
      s_data    = '0;
      res_ready = 1'b0;
      test_reset();
      test_hit_stream();
      test_miss_early();
      test_equal();
      test_gap_hold();
      test_reset_mid();
      test_hit_count();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
